// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the CPU datapath: ALU ops, opcode classes, one-hot selects,
// sequencer states and the instruction classes the sequencer branches on.
package cpu_defs;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_NOT = 2'b11;

   localparam logic [2:0] OPC_MOVC = 3'b110;
   localparam logic [2:0] OPC_ALUC = 3'b101;

   localparam logic [1:0] MOV_IMM_OP = 2'b10;
   localparam logic [1:0] MOV_REG_OP = 2'b00;

   localparam logic [2:0] NSEL_NONE = 3'b000;
   localparam logic [2:0] NSEL_RN   = 3'b001;
   localparam logic [2:0] NSEL_RD   = 3'b010;
   localparam logic [2:0] NSEL_RM   = 3'b100;

   localparam logic [3:0] VSEL_NONE  = 4'b0000;
   localparam logic [3:0] VSEL_C     = 4'b0001;
   localparam logic [3:0] VSEL_PC    = 4'b0010;
   localparam logic [3:0] VSEL_IMM   = 4'b0100;
   localparam logic [3:0] VSEL_MDATA = 4'b1000;

   typedef enum logic [2:0] {
      S_WAIT   = 3'd0,
      S_DECODE = 3'd1,
      S_GETA   = 3'd2,
      S_GETB   = 3'd3,
      S_EXEC   = 3'd4,
      S_WB     = 3'd5,
      S_WIMM   = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      CLS_MOVI    = 3'd0,
      CLS_MOVR    = 3'd1,
      CLS_ALU2    = 3'd2,
      CLS_MVN     = 3'd3,
      CLS_CMP     = 3'd4,
      CLS_ILLEGAL = 3'd5
   } instr_class_e;

endpackage

// File: rtl/alu_sequencer_decode.sv
// Combinational classifier: turns the latched opcode/op pair into the instruction
// class the sequencer FSM branches on.
module alu_seq_decode
   import cpu_defs::*;
(
   input  logic [2:0]   opcode,
   input  logic [1:0]   op,
   output instr_class_e cls
);

   always_comb begin
      cls = CLS_ILLEGAL;
      case (opcode)
         OPC_MOVC: begin
            if (op == MOV_IMM_OP)
               cls = CLS_MOVI;
            else if (op == MOV_REG_OP)
               cls = CLS_MOVR;
         end
         OPC_ALUC: begin
            case (op)
               ALU_ADD, ALU_AND: cls = CLS_ALU2;
               ALU_SUB:          cls = CLS_CMP;
               default:          cls = CLS_MVN;
            endcase
         end
         default: cls = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle Moore controller driving register-file, pipeline-register, status and
// ALU strobes for one decoded instruction at a time; w is high only while idle.
module alu_sequencer
   import cpu_defs::*;
#(
   parameter int NSEL_W = 3,
   parameter int VSEL_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s,
   input  logic [2:0]        opcode,
   input  logic [1:0]        op,
   output logic              w,
   output logic              err,
   output logic [NSEL_W-1:0] nsel,
   output logic [VSEL_W-1:0] vsel,
   output logic              loada,
   output logic              loadb,
   output logic              loadc,
   output logic              loads,
   output logic              asel,
   output logic              bsel,
   output logic [1:0]        ALUop,
   output logic              write
);

   state_e            state_q, state_d;
   logic [2:0]        opcode_q, opcode_d;
   logic [1:0]        op_q, op_d;
   logic              err_q, err_d;
   logic              w_q, w_d;
   logic [NSEL_W-1:0] nsel_q, nsel_d;
   logic [VSEL_W-1:0] vsel_q, vsel_d;
   logic              loada_q, loada_d;
   logic              loadb_q, loadb_d;
   logic              loadc_q, loadc_d;
   logic              loads_q, loads_d;
   logic              asel_q, asel_d;
   logic [1:0]        alu_op_q, alu_op_d;
   logic              write_q, write_d;
   instr_class_e      cls;

   alu_seq_decode u_decode (
      .opcode (opcode_q),
      .op     (op_q),
      .cls    (cls)
   );

   // Next state and instruction latch; the unused state encoding falls back to S_WAIT.
   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      op_d     = op_q;
      err_d    = err_q;
      case (state_q)
         S_WAIT: begin
            if (s) begin
               state_d  = S_DECODE;
               opcode_d = opcode;
               op_d     = op;
               err_d    = 1'b0;
            end
         end
         S_DECODE: begin
            case (cls)
               CLS_MOVI:           state_d = S_WIMM;
               CLS_MOVR, CLS_MVN:  state_d = S_GETB;
               CLS_ALU2, CLS_CMP:  state_d = S_GETA;
               default: begin
                  state_d = S_WAIT;
                  err_d   = 1'b1;
               end
            endcase
         end
         S_GETA:  state_d = S_GETB;
         S_GETB:  state_d = S_EXEC;
         S_EXEC:  state_d = (cls == CLS_CMP) ? S_WAIT : S_WB;
         default: state_d = S_WAIT;
      endcase
   end

   // Strobes are decoded from the state being entered so they register alongside it.
   always_comb begin
      w_d      = 1'b0;
      nsel_d   = NSEL_W'(NSEL_NONE);
      vsel_d   = VSEL_W'(VSEL_NONE);
      loada_d  = 1'b0;
      loadb_d  = 1'b0;
      loadc_d  = 1'b0;
      loads_d  = 1'b0;
      asel_d   = 1'b0;
      alu_op_d = ALU_ADD;
      write_d  = 1'b0;
      case (state_d)
         S_WAIT: w_d = 1'b1;
         S_GETA: begin
            nsel_d  = NSEL_W'(NSEL_RN);
            loada_d = 1'b1;
         end
         S_GETB: begin
            nsel_d  = NSEL_W'(NSEL_RM);
            loadb_d = 1'b1;
         end
         S_EXEC: begin
            alu_op_d = (cls == CLS_MOVR) ? ALU_ADD : op_q;
            asel_d   = (cls == CLS_MOVR) || (cls == CLS_MVN);
            if (cls == CLS_CMP) begin
               loads_d = 1'b1;
            end else begin
               loadc_d = 1'b1;
               loads_d = (cls == CLS_ALU2) || (cls == CLS_MVN);
            end
         end
         S_WB: begin
            nsel_d  = NSEL_W'(NSEL_RD);
            vsel_d  = VSEL_W'(VSEL_C);
            write_d = 1'b1;
         end
         S_WIMM: begin
            nsel_d  = NSEL_W'(NSEL_RN);
            vsel_d  = VSEL_W'(VSEL_IMM);
            write_d = 1'b1;
         end
         default: w_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_WAIT;
         opcode_q <= 3'b000;
         op_q     <= 2'b00;
         err_q    <= 1'b0;
         w_q      <= 1'b1;
         nsel_q   <= '0;
         vsel_q   <= '0;
         loada_q  <= 1'b0;
         loadb_q  <= 1'b0;
         loadc_q  <= 1'b0;
         loads_q  <= 1'b0;
         asel_q   <= 1'b0;
         alu_op_q <= 2'b00;
         write_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         op_q     <= op_d;
         err_q    <= err_d;
         w_q      <= w_d;
         nsel_q   <= nsel_d;
         vsel_q   <= vsel_d;
         loada_q  <= loada_d;
         loadb_q  <= loadb_d;
         loadc_q  <= loadc_d;
         loads_q  <= loads_d;
         asel_q   <= asel_d;
         alu_op_q <= alu_op_d;
         write_q  <= write_d;
      end
   end

   assign w     = w_q;
   assign err   = err_q;
   assign nsel  = nsel_q;
   assign vsel  = vsel_q;
   assign loada = loada_q;
   assign loadb = loadb_q;
   assign loadc = loadc_q;
   assign loads = loads_q;
   assign asel  = asel_q;
   assign bsel  = 1'b0;
   assign ALUop = alu_op_q;
   assign write = write_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: each issued instruction expands into its expected
// per-cycle output records, which a negedge monitor pops and compares.
module tb_alu_sequencer;

   typedef struct packed {
      logic       w;
      logic       err;
      logic [2:0] nsel;
      logic [3:0] vsel;
      logic       loada;
      logic       loadb;
      logic       loadc;
      logic       loads;
      logic       asel;
      logic       bsel;
      logic [1:0] alu_op;
      logic       write;
   } out_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       s;
   logic [2:0] opcode;
   logic [1:0] op;
   logic       w, err, loada, loadb, loadc, loads, asel, bsel, write;
   logic [2:0] nsel;
   logic [3:0] vsel;
   logic [1:0] alu_op;

   out_t  exp_q[$];
   string name_q[$];
   out_t  plan_q[$];
   string plan_n[$];

   int  checks = 0;
   int  errors = 0;
   int  writes_seen = 0;
   int  writes_exp = 0;
   bit  model_err = 1'b0;
   bit  plan_illegal;

   always #5 clk = ~clk;

   alu_sequencer #(.NSEL_W(3), .VSEL_W(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .s      (s),
      .opcode (opcode),
      .op     (op),
      .w      (w),
      .err    (err),
      .nsel   (nsel),
      .vsel   (vsel),
      .loada  (loada),
      .loadb  (loadb),
      .loadc  (loadc),
      .loads  (loads),
      .asel   (asel),
      .bsel   (bsel),
      .ALUop  (alu_op),
      .write  (write)
   );

   // Expected output records for each phase of an instruction.
   function automatic out_t recWait(input bit e);
      out_t r = '0;
      r.w   = 1'b1;
      r.err = e;
      return r;
   endfunction

   function automatic out_t recGetA();
      out_t r = '0;
      r.nsel  = 3'b001;
      r.loada = 1'b1;
      return r;
   endfunction

   function automatic out_t recGetB();
      out_t r = '0;
      r.nsel  = 3'b100;
      r.loadb = 1'b1;
      return r;
   endfunction

   function automatic out_t recExec(input logic [1:0] a, input bit zero_a, input bit lc, input bit ls);
      out_t r = '0;
      r.alu_op = a;
      r.asel   = zero_a;
      r.loadc  = lc;
      r.loads  = ls;
      return r;
   endfunction

   function automatic out_t recWrite(input logic [2:0] n, input logic [3:0] v);
      out_t r = '0;
      r.nsel  = n;
      r.vsel  = v;
      r.write = 1'b1;
      return r;
   endfunction

   task automatic addPlan(input out_t r, input string n);
      plan_q.push_back(r);
      plan_n.push_back(n);
   endtask

   // Reference model: expected records for cycles 1..L after the accepting edge.
   task automatic planInstr(input logic [2:0] opc, input logic [1:0] o);
      plan_q.delete();
      plan_n.delete();
      plan_illegal = 1'b0;
      addPlan('0, "decode");
      if (opc == 3'b110 && o == 2'b10) begin
         addPlan(recWrite(3'b001, 4'b0100), "movi_wr");
         writes_exp++;
      end else if (opc == 3'b110 && o == 2'b00) begin
         addPlan(recGetB(), "movr_getb");
         addPlan(recExec(2'b00, 1'b1, 1'b1, 1'b0), "movr_exec");
         addPlan(recWrite(3'b010, 4'b0001), "movr_wb");
         writes_exp++;
      end else if (opc == 3'b101 && o == 2'b11) begin
         addPlan(recGetB(), "mvn_getb");
         addPlan(recExec(2'b11, 1'b1, 1'b1, 1'b1), "mvn_exec");
         addPlan(recWrite(3'b010, 4'b0001), "mvn_wb");
         writes_exp++;
      end else if (opc == 3'b101 && o == 2'b01) begin
         addPlan(recGetA(), "cmp_geta");
         addPlan(recGetB(), "cmp_getb");
         addPlan(recExec(2'b01, 1'b0, 1'b0, 1'b1), "cmp_exec");
      end else if (opc == 3'b101) begin
         addPlan(recGetA(), "alu_geta");
         addPlan(recGetB(), "alu_getb");
         addPlan(recExec(o, 1'b0, 1'b1, 1'b1), "alu_exec");
         addPlan(recWrite(3'b010, 4'b0001), "alu_wb");
         writes_exp++;
      end else begin
         plan_illegal = 1'b1;
      end
      addPlan(recWait(plan_illegal), "done_wait");
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic expectCycle(input out_t r, input string n);
      exp_q.push_back(r);
      name_q.push_back(n);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         nextCycle();
         s = 1'b0;
         expectCycle(recWait(model_err), "idle_wait");
      end
   endtask

   // Issue one instruction from an idle cycle; scramble drives opcode 110 while busy.
   task automatic applyStimulus(input logic [2:0] opc, input logic [1:0] o,
                                input bit hold_s, input bit scramble);
      planInstr(opc, o);
      s      = 1'b1;
      opcode = opc;
      op     = o;
      for (int k = 0; k < plan_q.size(); k++) begin
         nextCycle();
         expectCycle(plan_q[k], plan_n[k]);
         if (k < plan_q.size() - 1) begin
            s = hold_s ? 1'b1 : 1'($urandom_range(0, 1));
            if (scramble) begin
               opcode = 3'b110;
               op     = 2'($urandom);
            end
         end else begin
            s = 1'b0;
         end
      end
      model_err = plan_illegal;
   endtask

   task automatic resetMidAdd();
      s      = 1'b1;
      opcode = 3'b101;
      op     = 2'b00;
      nextCycle();
      expectCycle('0, "rst_decode");
      s = 1'b0;
      nextCycle();
      expectCycle(recGetA(), "rst_geta");
      nextCycle();
      expectCycle(recGetB(), "rst_getb");
      reset = 1'b1;
      nextCycle();
      expectCycle(recWait(1'b0), "rst_idle");
      reset     = 1'b0;
      model_err = 1'b0;
   endtask

   task automatic checkOutput(input string n, input out_t act, input out_t req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got %b required %b (w,err,nsel,vsel,la,lb,lc,ls,asel,bsel,aluop,wr)",
                  n, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (write === 1'b1)
         writes_seen++;
      if (exp_q.size() > 0) begin
         automatic out_t  req = exp_q.pop_front();
         automatic string n   = name_q.pop_front();
         automatic out_t  act = '{w, err, nsel, vsel, loada, loadb, loadc, loads,
                                  asel, bsel, alu_op, write};
         checkOutput(n, act, req);
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL timeout: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [2:0] ropc;
      logic [1:0] rop;
      int drain;
      reset  = 1'b1;
      s      = 1'b0;
      opcode = 3'b000;
      op     = 2'b00;
      nextCycle();
      expectCycle(recWait(1'b0), "reset_idle");
      nextCycle();
      expectCycle(recWait(1'b0), "reset_idle");
      reset = 1'b0;
      idle(2);

      $display("[TB] directed instructions");
      applyStimulus(3'b110, 2'b10, 1'b0, 1'b0);
      idle(1);
      applyStimulus(3'b101, 2'b00, 1'b0, 1'b0);
      idle(1);
      applyStimulus(3'b101, 2'b01, 1'b1, 1'b0);
      applyStimulus(3'b101, 2'b11, 1'b1, 1'b0);
      idle(1);
      applyStimulus(3'b111, 2'b00, 1'b0, 1'b0);
      idle(2);
      applyStimulus(3'b110, 2'b00, 1'b0, 1'b0);
      idle(1);
      applyStimulus(3'b110, 2'b01, 1'b0, 1'b0);
      applyStimulus(3'b101, 2'b10, 1'b0, 1'b1);
      idle(1);
      resetMidAdd();
      idle(1);

      $display("[TB] random instructions");
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            ropc = 3'($urandom);
            rop  = 2'($urandom);
         end else begin
            ropc = ($urandom_range(0, 1) == 1) ? 3'b101 : 3'b110;
            rop  = 2'($urandom);
         end
         applyStimulus(ropc, rop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         idle($urandom_range(0, 2));
      end

      drain = 0;
      while (exp_q.size() > 0 && drain < 10) begin
         @(negedge clk);
         drain++;
      end
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d records left, required 0", exp_q.size());
      end
      checks++;
      if (writes_seen != writes_exp) begin
         errors++;
         $display("[TB] FAIL write_count: got %0d required %0d", writes_seen, writes_exp);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
